// File: rtl/data_mem_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline memory stage (M)
// and the debug/loader port (D); every access runs IDLE -> ISSUE -> RESP.
module data_mem_port_arbiter #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [63:0]       m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_adr_err,
  output logic              m_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_adr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              owner_d;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              m_cand;
  logic              d_cand;
  logic              grant_d;
  logic              grant_any;
  logic [63:0]       sel_addr;
  logic              issue;

  // A requester being acked this cycle is still showing its finished request.
  assign m_cand    = m_req & ~m_ack;
  assign d_cand    = d_req & ~d_ack;
  assign grant_d   = d_cand & ((starve_cnt == CNT_MAX) | ~m_cand);
  assign grant_any = m_cand | d_cand;
  assign sel_addr  = grant_d ? d_addr : m_addr;

  // Memory strobes follow the state register so reset kills them at once.
  assign issue     = (state == ISSUE);
  assign mem_en    = issue & ~err_q;
  assign mem_we    = issue & we_q & ~err_q;
  assign mem_addr  = (issue & ~err_q) ? addr_q : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign busy      = (state != IDLE);
  assign m_stall   = m_req & ~m_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m_ack      <= 1'b0;
      d_ack      <= 1'b0;
      m_adr_err  <= 1'b0;
      d_adr_err  <= 1'b0;
      m_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      m_ack     <= 1'b0;
      d_ack     <= 1'b0;
      m_adr_err <= 1'b0;
      d_adr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner_d <= grant_d;
            we_q    <= grant_d ? d_we : m_we;
            wdata_q <= grant_d ? d_wdata : m_wdata;
            addr_q  <= sel_addr[ADDR_W-1:0];
            err_q   <= (sel_addr > MAX_ADDR);
            if (grant_d || !d_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: state <= RESP;
        RESP: begin
          if (owner_d) begin
            d_ack     <= 1'b1;
            d_adr_err <= err_q;
            if (!we_q && !err_q) d_rdata <= mem_rdata;
          end else begin
            m_ack     <= 1'b1;
            m_adr_err <= err_q;
            if (!we_q && !err_q) m_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// Bench for data_mem_port_arbiter: transaction-level model with a shadow memory,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_data_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req, m_we, d_req, d_we;
  logic [63:0] m_addr, m_wdata, d_addr, d_wdata;
  logic        m_ack, m_adr_err, m_stall, d_ack, d_adr_err;
  logic [63:0] m_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  data_mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_adr_err(m_adr_err), .m_stall(m_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_adr_err(d_adr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's independent copy of it.
  logic [63:0] ram    [4096];
  logic [63:0] shadow [4096];
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 64'(i + 1);
      shadow[i] = 64'(i + 1);
    end
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Transaction model: a grant in cycle t strobes memory in t+1 and acks in t+3.
  int          cyc = 0;
  int          tg = 0;
  int          starve = 0;
  bit          have = 0;
  bit          t_d, t_we, t_err;
  logic [63:0] t_addr, t_data, rd_tmp;
  logic [63:0] exp_mr = '0;
  logic [63:0] exp_dr = '0;

  always @(negedge clk) begin
    bit ack_now, e_mack, e_dack, iss, e_en, mv, dv, gd;
    if (reset) begin
      have = 0; starve = 0; exp_mr = '0; exp_dr = '0;
    end
    ack_now = have && (cyc == tg + 3);
    if (ack_now && !t_err && !t_we) begin
      if (t_d) exp_dr = rd_tmp;
      else exp_mr = rd_tmp;
    end
    e_mack = ack_now && !t_d;
    e_dack = ack_now && t_d;
    iss    = have && (cyc == tg + 1);
    e_en   = iss && !t_err;
    chk("m_ack", 64'(m_ack), 64'(e_mack));
    chk("d_ack", 64'(d_ack), 64'(e_dack));
    chk("m_adr_err", 64'(m_adr_err), 64'(e_mack && t_err));
    chk("d_adr_err", 64'(d_adr_err), 64'(e_dack && t_err));
    chk("m_rdata", m_rdata, exp_mr);
    chk("d_rdata", d_rdata, exp_dr);
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_en && t_we));
    chk("mem_addr", 64'(mem_addr), e_en ? 64'(t_addr[11:0]) : 64'd0);
    chk("mem_wdata", mem_wdata, iss ? t_data : 64'd0);
    chk("busy", 64'(busy), 64'(have && (cyc == tg + 1 || cyc == tg + 2)));
    chk("m_stall", 64'(m_stall), 64'(m_req && !e_mack));
    if (!reset) begin
      if (e_en && t_we) shadow[t_addr[11:0]] = t_data;
      if (e_en && !t_we) rd_tmp = shadow[t_addr[11:0]];
      mv = m_req && !e_mack;
      dv = d_req && !e_dack;
      if ((!have || cyc >= tg + 3) && (mv || dv)) begin
        gd     = dv && (starve == 4 || !mv);
        have   = 1;
        tg     = cyc;
        t_d    = gd;
        t_we   = gd ? d_we : m_we;
        t_addr = gd ? d_addr : m_addr;
        t_data = gd ? d_wdata : m_wdata;
        t_err  = (t_addr > 64'd4095);
        if (gd || !d_req) starve = 0;
        else if (starve < 4) starve = starve + 1;
      end
    end
    cyc++;
  end

  // One access on port M (isd=0) or D (isd=1); inputs are scrambled after the grant.
  task automatic txn(input bit isd, input bit we, input logic [63:0] addr,
                     input logic [63:0] data, output int lat, output bit saw_en,
                     output bit err, output logic [63:0] rd);
    lat = 0; saw_en = 0; err = 0; rd = '0;
    if (isd) begin d_we = we; d_addr = addr; d_wdata = data; d_req = 1; end
    else begin m_we = we; m_addr = addr; m_wdata = data; m_req = 1; end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (isd) begin d_we = ~we; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; end
      else begin m_we = ~we; m_addr = {$urandom, $urandom}; m_wdata = {$urandom, $urandom}; end
      if (mem_en) saw_en = 1;
      if (isd ? d_ack : m_ack) begin
        lat = i;
        err = isd ? d_adr_err : m_adr_err;
        rd  = isd ? d_rdata : m_rdata;
        if (isd) d_req = 0; else m_req = 0;
        break;
      end
    end
    if (lat == 0) chk("txn_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, mack, dack;
    bit en, err;
    logic [63:0] rd;
    reset = 1; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_m_rdata", m_rdata, 64'd0);
    reset = 0;
    @(posedge clk); #1;

    txn(0, 0, 64'd10, 64'd0, lat, en, err, rd);
    chk("rd10_lat", 64'(lat), 64'd3);
    chk("rd10_data", rd, 64'd11);
    chk("rd10_err", 64'(err), 64'd0);
    chk("rd10_mem_en", 64'(en), 64'd1);

    txn(0, 1, 64'd4095, 64'h55, lat, en, err, rd);
    chk("wr4095_lat", 64'(lat), 64'd3);
    chk("wr4095_mem_en", 64'(en), 64'd1);
    txn(0, 0, 64'd4095, 64'd0, lat, en, err, rd);
    chk("rd4095_data", rd, 64'h55);

    txn(0, 0, 64'd4096, 64'd0, lat, en, err, rd);
    chk("rd4096_lat", 64'(lat), 64'd3);
    chk("rd4096_err", 64'(err), 64'd1);
    chk("rd4096_no_mem", 64'(en), 64'd0);
    chk("rd4096_rdata_kept", rd, 64'h55);
    txn(0, 1, 64'h8000_0000_0000_0010, 64'hBAD, lat, en, err, rd);
    chk("wr_hi_err", 64'(err), 64'd1);
    chk("wr_hi_no_mem", 64'(en), 64'd0);
    chk("ram16_intact", ram[16], 64'd17);

    txn(1, 0, 64'd20, 64'd0, lat, en, err, rd);
    chk("d_rd20_lat", 64'(lat), 64'd3);
    chk("d_rd20_data", rd, 64'd21);

    // Simultaneous requests: M first, D follows back to back.
    m_we = 0; m_addr = 64'd5; d_we = 0; d_addr = 64'd6;
    m_req = 1; d_req = 1; mack = 0; dack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (m_ack) begin mack = i; m_req = 0; end
      if (d_ack) begin dack = i; d_req = 0; end
    end
    chk("both_m_ack_cycle", 64'(mack), 64'd3);
    chk("both_d_ack_cycle", 64'(dack), 64'd6);
    chk("both_m_rdata", m_rdata, 64'd6);
    chk("both_d_rdata", d_rdata, 64'd7);

    // Both ports requesting continuously; the model tracks every grant.
    m_we = 0; m_addr = 64'd30; d_we = 1; d_addr = 64'd31; d_wdata = 64'hD00D;
    m_req = 1; d_req = 1;
    repeat (24) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (m_ack) m_req = 0;
      if (d_ack) d_req = 0;
      if (!m_req && !d_req && !busy) break;
      @(posedge clk); #1;
    end
    chk("cont_drained", 64'(m_req | d_req | busy), 64'd0);
    @(posedge clk); #1;
    txn(0, 0, 64'd31, 64'd0, lat, en, err, rd);
    chk("cont_d_write", rd, 64'hD00D);

    // Reset during the ISSUE cycle of an M write aborts it.
    m_we = 1; m_addr = 64'd100; m_wdata = 64'hDEAD; m_req = 1;
    @(posedge clk); #1;
    chk("pre_rst_mem_we", 64'(mem_we), 64'd1);
    reset = 1;
    #1;
    chk("rst_mem_we_drop", 64'(mem_we), 64'd0);
    chk("rst_busy_drop", 64'(busy), 64'd0);
    m_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_ack", 64'(m_ack), 64'd0);
    reset = 0;
    @(posedge clk); #1;
    txn(0, 0, 64'd100, 64'd0, lat, en, err, rd);
    chk("rst_mem_unchanged", rd, 64'd101);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
